config_loader: RTL and testbench



---
 rtl/kfpga_cfg_pkg.sv | 17 +
 rtl/config_word_router.sv | 66 ++++++
 rtl/config_loader.sv | 107 ++++++++++
 tb/tb_config_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/kfpga_cfg_pkg.sv
// Shared constants for the grid configuration loader: geometry and FSM states.
package kfpga_cfg_pkg;

  localparam int WORD_WIDTH       = 32;
  localparam int COLUMNS          = 8;
  localparam int COLUMN_BITS      = 4192;
  localparam int WORDS_PER_COLUMN = COLUMN_BITS / WORD_WIDTH;
  localparam int TOTAL_WORDS      = COLUMNS * WORDS_PER_COLUMN;

  // Loader FSM encoding, kept as plain constants for compatibility with older tools.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/config_word_router.sv
// Registered forwarder: presents each accepted word to one column chain with a
// one-cycle shift pulse, and tracks which word/column of the frame comes next.
module config_word_router #(
  parameter int WORD_WIDTH       = 32,
  parameter int COLUMNS          = 8,
  parameter int WORDS_PER_COLUMN = 131
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  fwd,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  last_word,
  output logic [WORD_WIDTH-1:0] cfg_word,
  output logic                  cfg_shift,
  output logic [COLUMNS-1:0]    cfg_column
);

  localparam int WIDX_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
  localparam int CIDX_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  logic [WIDX_W-1:0]  word_idx_reg;
  logic [CIDX_W-1:0]  col_idx_reg;
  logic [COLUMNS-1:0] col_hot;
  logic               word_wrap;

  // One-hot decode of the current column index.
  generate
    for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_col_hot
      assign col_hot[gi] = (col_idx_reg == CIDX_W'(gi));
    end
  endgenerate

  assign word_wrap = (word_idx_reg == WIDX_W'(WORDS_PER_COLUMN - 1));
  // Next accepted word is the final payload word of the frame.
  assign last_word = word_wrap && (col_idx_reg == CIDX_W'(COLUMNS - 1));

  // Forward the accepted word one cycle later and advance the word/column counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_idx_reg <= '0;
      col_idx_reg  <= '0;
      cfg_word     <= '0;
      cfg_shift    <= 1'b0;
      cfg_column   <= '0;
    end else begin
      cfg_shift  <= fwd;
      cfg_column <= fwd ? col_hot : '0;
      if (fwd) begin
        cfg_word <= data;
      end
      if (clear) begin
        word_idx_reg <= '0;
        col_idx_reg  <= '0;
      end else if (fwd) begin
        if (word_wrap) begin
          word_idx_reg <= '0;
          col_idx_reg  <= col_idx_reg + 1'b1;
        end else begin
          word_idx_reg <= word_idx_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Grid configuration loader: accepts a word stream, routes it to the column
// chains, verifies the trailing XOR checksum and then releases the grid reset.
module config_loader #(
  parameter int WORD_WIDTH  = kfpga_cfg_pkg::WORD_WIDTH,
  parameter int COLUMNS     = kfpga_cfg_pkg::COLUMNS,
  parameter int COLUMN_BITS = kfpga_cfg_pkg::COLUMN_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WORD_WIDTH-1:0] cfg_word,
  output logic                  cfg_shift,
  output logic [COLUMNS-1:0]    cfg_column,
  output logic                  grid_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  import kfpga_cfg_pkg::*;

  // Derived from the geometry; deliberately not a parameter.
  localparam int WORDS_PER_COLUMN = COLUMN_BITS / WORD_WIDTH;

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [WORD_WIDTH-1:0] checksum_reg;
  logic                  load_init;
  logic                  fwd;
  logic                  last_word;

  config_word_router #(
    .WORD_WIDTH       (WORD_WIDTH),
    .COLUMNS          (COLUMNS),
    .WORDS_PER_COLUMN (WORDS_PER_COLUMN)
  ) u_router (
    .clock      (clock),
    .reset      (reset),
    .clear      (load_init),
    .fwd        (fwd),
    .data       (s_data),
    .last_word  (last_word),
    .cfg_word   (cfg_word),
    .cfg_shift  (cfg_shift),
    .cfg_column (cfg_column)
  );

  // Next-state logic; abort beats start while loading, start beats abort otherwise.
  always_comb begin
    state_next = state_reg;
    load_init  = 1'b0;
    fwd        = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_LOAD;
          load_init  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (s_valid) begin
          fwd = 1'b1;
          if (last_word) begin
            state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (s_valid) begin
          state_next = (s_data == checksum_reg) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, running checksum and grid reset release (one cycle after reaching DONE).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      checksum_reg <= '0;
      grid_nreset  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grid_nreset <= (state_reg == ST_DONE) && (state_next == ST_DONE);
      if (load_init) begin
        checksum_reg <= '0;
      end else if (fwd) begin
        checksum_reg <= checksum_reg ^ s_data;
      end
    end
  end

  assign s_ready = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
  assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
  assign done    = (state_reg == ST_DONE);
  assign error   = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: control-vector table, full loads with
// sequential and random payloads, random valid gaps, bad trailer, abort, reset.
module tb_config_loader;

  localparam int WW    = 32;
  localparam int NCOL  = 8;
  localparam int WPC   = 4192 / 32;
  localparam int TOTAL = NCOL * WPC;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [WW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [WW-1:0]   cfg_word;
  logic            cfg_shift;
  logic [NCOL-1:0] cfg_column;
  logic            grid_nreset;
  logic            busy;
  logic            done;
  logic            error;

  int checks = 0;
  int errors = 0;

  // Reference payload and observed forwarded stream {column, word}.
  logic [WW-1:0]        words [0:TOTAL-1];
  logic [NCOL+WW-1:0]   obs_q [$];

  config_loader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cfg_word    (cfg_word),
    .cfg_shift   (cfg_shift),
    .cfg_column  (cfg_column),
    .grid_nreset (grid_nreset),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  // Capture every forwarded word away from the active edge.
  always @(negedge clock) begin
    if (cfg_shift === 1'b1) obs_q.push_back({cfg_column, cfg_word});
  end

  typedef struct {
    bit         start;
    bit         abort;
    bit         valid;
    logic [5:0] exp;   // {s_ready, busy, done, error, cfg_shift, grid_nreset}
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one word until it is accepted, optionally with random valid gaps.
  task automatic send(input logic [WW-1:0] d, input bit gaps);
    int  budget;
    bit  xfer;
    budget = 0;
    xfer   = 1'b0;
    while (!xfer) begin
      s_data  = d;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer    = s_valid && s_ready;
      step();
      budget++;
      if (!xfer && budget > 500) begin
        $display("FAIL send_timeout: word %0h not accepted after %0d cycles", d, budget);
        $fatal(1, "handshake stalled");
      end
    end
    s_valid = 1'b0;
  endtask

  // Compare the observed forwarded stream with the first n reference words,
  // each expected in column (index / words-per-column).
  task automatic check_seq(input string tag, input int n);
    int         bad;
    logic [7:0] col;
    bad = 0;
    if (obs_q.size() != n) bad++;
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      col = 8'd1 << (i / WPC);
      if (obs_q[i] !== {col, words[i]}) bad++;
    end
    check({tag, "_seq_bad"}, 64'(bad), 0);
  endtask

  task automatic full_load(input bit gaps, input bit rand_data, input logic [WW-1:0] flip,
                           input string tag);
    logic [WW-1:0] x;
    bit            ok;
    x  = '0;
    ok = (flip == '0);
    obs_q.delete();
    do_start();
    for (int i = 0; i < TOTAL; i++) begin
      words[i] = rand_data ? $urandom : WW'(i);
      x ^= words[i];
      send(words[i], gaps);
    end
    send(x ^ flip, gaps);
    check({tag, "_t1_done_err_nrst"}, {done, error, grid_nreset}, ok ? 3'b100 : 3'b010);
    step();
    check({tag, "_t2_done_err_nrst_busy"}, {done, error, grid_nreset, busy},
          ok ? 4'b1010 : 4'b0100);
    check_seq(tag, TOTAL);
  endtask

  initial begin
    vec_t vecs [9];
    int   bad;
    int   cnt;

    vecs[0] = '{0, 0, 1, 6'b000000};  // idle, valid ignored
    vecs[1] = '{0, 1, 1, 6'b000000};  // abort in idle ignored
    vecs[2] = '{1, 0, 0, 6'b110000};  // start -> LOAD
    vecs[3] = '{0, 0, 1, 6'b110010};  // transfer forwarded next cycle
    vecs[4] = '{1, 0, 0, 6'b110000};  // start in LOAD ignored
    vecs[5] = '{0, 1, 1, 6'b000000};  // abort discards same-cycle word
    vecs[6] = '{1, 1, 0, 6'b110000};  // start wins in IDLE
    vecs[7] = '{1, 1, 1, 6'b000000};  // abort wins in LOAD, word discarded
    vecs[8] = '{0, 0, 0, 6'b000000};

    // Reset values.
    reset = 1'b1;
    repeat (3) step();
    check("reset_outputs", {s_ready, busy, done, error, cfg_shift, grid_nreset, cfg_column, cfg_word},
          '0);
    reset = 1'b0;

    // Idle with valid asserted: nothing accepted, nothing forwarded.
    bad = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = $urandom;
      step();
      if (s_ready !== 1'b0 || cfg_shift !== 1'b0 || grid_nreset !== 1'b0) bad++;
    end
    s_valid = 1'b0;
    check("idle_quiet", 64'(bad), 0);

    // Control vector table.
    for (int i = 0; i < 9; i++) begin
      start   = vecs[i].start;
      abort   = vecs[i].abort;
      s_valid = vecs[i].valid;
      s_data  = $urandom;
      step();
      start   = 1'b0;
      abort   = 1'b0;
      s_valid = 1'b0;
      check($sformatf("vec%0d_ctrl", i), {s_ready, busy, done, error, cfg_shift, grid_nreset},
            vecs[i].exp);
    end

    // Sequential payload, no gaps; per-column pulse counts.
    full_load(1'b0, 1'b0, '0, "seq_load");
    for (int c = 0; c < NCOL; c++) begin
      cnt = 0;
      foreach (obs_q[k]) if (obs_q[k][WW+c]) cnt++;
      check($sformatf("colcount_%0d", c), 64'(cnt), WPC);
    end

    // Random payload with ~50% valid gaps.
    full_load(1'b1, 1'b1, '0, "gap_load");

    // Corrupted trailer, then a good reload from ERROR.
    full_load(1'b0, 1'b0, 32'h1, "bad_trailer");
    full_load(1'b0, 1'b1, '0, "reload_after_err");

    // Abort after word 500: the next offered word is discarded.
    obs_q.delete();
    do_start();
    for (int i = 0; i <= 500; i++) begin
      words[i] = $urandom;
      send(words[i], 1'b0);
    end
    s_valid = 1'b1;
    s_data  = 32'hdeadbeef;
    abort   = 1'b1;
    step();
    abort   = 1'b0;
    s_valid = 1'b0;
    repeat (3) step();
    check("abort_state", {s_ready, busy, done, error, grid_nreset}, 5'b00000);
    check_seq("abort", 501);
    full_load(1'b1, 1'b1, '0, "load_after_abort");

    // Restart from DONE: grid goes back into reset immediately, then reset mid-load.
    do_start();
    check("restart_nrst_busy_done", {grid_nreset, busy, done}, 3'b010);
    for (int i = 0; i <= 10; i++) begin
      send(WW'(i), 1'b0);
    end
    reset = 1'b1;
    step();
    check("midload_reset_outputs",
          {s_ready, busy, done, error, cfg_shift, grid_nreset, cfg_column, cfg_word}, '0);
    reset = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
